spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
SPI master shift engine. Consumes the 34-bit {slave_select[1:0], tx_data[31:0]} word presented by the data buffer over the go/DREADY/SRESP handshake. Serialises tx_data on MOSI (SPI mode 0) while capturing MISO, then hands the 32-bit received word to the Rx FIFO with a valid/ready handshake.

Parameters:
DATA_W, 32, bits per SPI frame
SS_W, 2, width of slave-select field; decoded to 2**SS_W chip selects
CLK_DIV, 4, SCLK cycles per SPI clock half-period (legal: >=1)

Ports:
SCLK  in  1  system clock; all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
start  in  1  level; enable continuous transfers while high
go  out  1  one-cycle request to data buffer for next word
DREADY  in  1  data buffer word valid on din
din  in  DATA_W+SS_W  {ss_sel, tx_data} from data buffer
SRESP  out  1  one-cycle acknowledge that din was captured
spi_sck  out  1  SPI clock, idles low
mosi  out  1  serial data out
miso  in  1  serial data in
ss_n  out  2**SS_W  active-low chip selects
rx_data  out  DATA_W  received word to Rx FIFO
rx_valid  out  1  rx_data valid
rx_ready  in  1  Rx FIFO can accept
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE. Outputs reset: go=0, SRESP=0, spi_sck=0, mosi=0, ss_n=all 1s, rx_data=0, rx_valid=0, busy=0. Takes effect mid-frame immediately: ss_n deasserts, frame discarded, no rx_valid.
- States: IDLE, REQ, WAIT_DATA, ACK, SHIFT, DESEL, PUSH.
- IDLE: start=1 -> REQ.
- REQ: go=1 for exactly one cycle -> WAIT_DATA.
- WAIT_DATA: wait indefinitely for DREADY=1. On that cycle:
  - capture tx_data into tx shift register and ss_sel;
  - SRESP=1 next cycle, for one cycle only;
  - -> ACK.
- ACK: SRESP=0. Stay until DREADY=0, which guarantees no double capture. Then:
  - drive ss_n[ss_sel]=0, others 1;
  - mosi=first bit; divider=0;
  - -> SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1; on terminal count spi_sck toggles.
  - Rising spi_sck edge: shift miso into rx shift register.
  - Falling edge: mosi advances to next bit.
  - After the DATA_W-th falling edge (spi_sck low): -> DESEL.
  - Duration exactly 2*DATA_W*CLK_DIV cycles. First rising edge occurs CLK_DIV cycles after ss_n falls (setup half-period).
- DESEL:
  - ss_n=all 1s for CLK_DIV cycles;
  - rx_data loaded from rx shift register;
  - -> PUSH with rx_valid=1.
- PUSH:
  - rx_valid and rx_data held stable until rx_ready=1.
  - Transfer completes on the cycle rx_valid&rx_ready.
  - Next cycle rx_valid=0. Then start=1 -> REQ, else IDLE.
  - Rx FIFO full (rx_ready=0) stalls the engine; no new go is issued (backpressure, no overwrite).
- start deasserted mid-frame: current frame completes through PUSH, then IDLE.
- ss_sel decode: value k selects ss_n[k] low. Exactly one line low during SHIFT, never more.
- Bit order: MSB first (tx_data[DATA_W-1] first; first miso bit lands in rx_data[DATA_W-1]).
- spi_sck always low outside SHIFT. mosi holds its last value outside SHIFT.
- Back-to-back latency with DREADY answered in 3 cycles and rx_ready=1: go to next go = 2*DATA_W*CLK_DIV + CLK_DIV + ~8 cycles.

Optional Feature:
SPI_LSB_FIRST_EN.
- Defined: tx_data[0] shifted first; first sampled miso bit lands in rx_data[0].
- Undefined: MSB first, as above.
- Timing and handshakes identical in both builds.

Test Plan:
1. Reset, start=1 -> go pulses 1 cycle. Buffer returns DREADY with din={2'b10,32'hA5A5_0F0F}. Required response:
   - SRESP is a single pulse;
   - ss_n=4'b1011;
   - mosi bit sequence equals 32'hA5A5_0F0F MSB first;
   - 32 spi_sck pulses, period 8 SCLK.
2. miso driven from 32'hDEAD_BEEF (changed on falling edges), rx_ready=1 -> rx_valid one cycle with rx_data=32'hDEAD_BEEF.
3. rx_ready=0 for 20 cycles after DESEL -> rx_valid and rx_data held stable; no go issued. rx_ready=1 -> single transfer, then next go.
4. DREADY held high 3 extra cycles after SRESP -> only one capture; SHIFT starts only after DREADY falls.
5. ARESETN asserted at bit 17 of SHIFT -> ss_n=4'b1111 and spi_sck=0 same cycle; no rx_valid; after release go occurs only once start=1.
6. CLK_DIV=1, start held high, 3 words ss_sel=0,1,3 -> correct ss_n per frame; ss_n all high ≥1 cycle between frames; 3 rx_valid.

Source files
------------

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode-0 master shift engine between a data buffer and an Rx FIFO.
// Build option SPI_LSB_FIRST_EN shifts LSB first; default build shifts MSB first.
module spi_shift_engine #(
  parameter int DATA_W  = 32,
  parameter int SS_W    = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                   SCLK,
  input  logic                   ARESETN,
  input  logic                   start,
  output logic                   go,
  input  logic                   DREADY,
  input  logic [DATA_W+SS_W-1:0] din,
  output logic                   SRESP,
  output logic                   spi_sck,
  output logic                   mosi,
  input  logic                   miso,
  output logic [(1<<SS_W)-1:0]   ss_n,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   busy
);
  localparam int NS    = 1 << SS_W;
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, ACK, SHIFT, DESEL, PUSH} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_next, rx_next;
  logic [SS_W-1:0] ss_sel_q, ss_sel_d;
  logic [NS-1:0] ss_n_q, ss_n_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic sresp_q, sresp_d, sck_q, sck_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d;
  logic tc, tx_bit;
  assign tc = div_q == DIV_W'(CLK_DIV - 1);
`ifdef SPI_LSB_FIRST_EN
  assign tx_bit  = tx_q[0];
  assign tx_next = tx_q >> 1;
  assign rx_next = {miso, rx_sh_q[DATA_W-1:1]};
`else
  assign tx_bit  = tx_q[DATA_W-1];
  assign tx_next = tx_q << 1;
  assign rx_next = {rx_sh_q[DATA_W-2:0], miso};
`endif
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    ss_sel_d   = ss_sel_q;
    ss_n_d     = ss_n_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sresp_d    = 1'b0;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    rx_valid_d = rx_valid_q;
    unique case (state_q)
      IDLE: state_d = start ? REQ : IDLE;
      REQ: state_d = WAIT_DATA;
      WAIT_DATA: if (DREADY) begin
        tx_d     = din[DATA_W-1:0];
        ss_sel_d = din[DATA_W+SS_W-1:DATA_W];
        sresp_d  = 1'b1;
        state_d  = ACK;
      end
      // holding here until DREADY drops prevents a second capture of the same word
      ACK: if (!DREADY) begin
        ss_n_d  = ~(NS'(1) << ss_sel_q);
        mosi_d  = tx_bit;
        tx_d    = tx_next;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        div_d = tc ? '0 : div_q + 1'b1;
        if (tc) begin
          sck_d = ~sck_q;
          if (!sck_q) rx_sh_d = rx_next;
          else if (bit_q == BIT_W'(DATA_W - 1)) begin
            ss_n_d  = '1;
            state_d = DESEL;
          end else begin
            mosi_d = tx_bit;
            tx_d   = tx_next;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      DESEL: begin
        div_d = tc ? '0 : div_q + 1'b1;
        if (tc) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = PUSH;
        end
      end
      PUSH: if (rx_ready) begin
        rx_valid_d = 1'b0;
        state_d    = start ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge SCLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      ss_sel_q   <= '0;
      ss_n_q     <= '1;
      div_q      <= '0;
      bit_q      <= '0;
      sresp_q    <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      ss_sel_q   <= ss_sel_d;
      ss_n_q     <= ss_n_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sresp_q    <= sresp_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end
  assign go       = state_q == REQ;
  assign busy     = state_q != IDLE;
  assign SRESP    = sresp_q;
  assign spi_sck  = sck_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed scoreboard bench for spi_shift_engine.
// Instance u0 uses CLK_DIV=4, u1 uses CLK_DIV=1; sel picks which one the frame task drives.
module tb_spi_shift_engine;
  logic SCLK = 1'b0, ARESETN = 1'b0, start0 = 1'b0, start1 = 1'b0, DREADY = 1'b0;
  logic miso = 1'b0, rx_ready = 1'b0, sel = 1'b0, bad;
  logic [33:0] din = '0;
  logic go0, go1, sresp0, sresp1, sck0, sck1, mosi0, mosi1, rxv0, rxv1, busy0, busy1;
  logic [3:0] ss0, ss1, ss_m;
  logic [31:0] rxd0, rxd1, rxd_m;
  logic go_m, sresp_m, sck_m, mosi_m, rxv_m, busy_m;
  int errors = 0, checks = 0, hs0 = 0, hs1 = 0;
  logic [31:0] exp_q[$];

  always #5 SCLK = ~SCLK;

  spi_shift_engine u0 (
    .SCLK(SCLK), .ARESETN(ARESETN), .start(start0), .go(go0), .DREADY(DREADY), .din(din),
    .SRESP(sresp0), .spi_sck(sck0), .mosi(mosi0), .miso(miso), .ss_n(ss0), .rx_data(rxd0),
    .rx_valid(rxv0), .rx_ready(rx_ready), .busy(busy0)
  );
  spi_shift_engine #(.CLK_DIV(1)) u1 (
    .SCLK(SCLK), .ARESETN(ARESETN), .start(start1), .go(go1), .DREADY(DREADY), .din(din),
    .SRESP(sresp1), .spi_sck(sck1), .mosi(mosi1), .miso(miso), .ss_n(ss1), .rx_data(rxd1),
    .rx_valid(rxv1), .rx_ready(rx_ready), .busy(busy1)
  );

  assign go_m    = sel ? go1 : go0;
  assign sresp_m = sel ? sresp1 : sresp0;
  assign sck_m   = sel ? sck1 : sck0;
  assign mosi_m  = sel ? mosi1 : mosi0;
  assign rxv_m   = sel ? rxv1 : rxv0;
  assign busy_m  = sel ? busy1 : busy0;
  assign ss_m    = sel ? ss1 : ss0;
  assign rxd_m   = sel ? rxd1 : rxd0;

  always @(posedge SCLK) begin
    hs0 <= hs0 + int'(rxv0 && rx_ready);
    hs1 <= hs1 + int'(rxv1 && rx_ready);
  end

  task automatic tick;
    @(negedge SCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bi(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return 31 - k;
`endif
  endfunction

  task automatic frame(input logic [1:0] ss, input logic [31:0] tx, input logic [31:0] rx,
                       input int extra, input int hold, input bit abort, input bit drop);
    int n, srs, rises, falls, last_r, first_r, per_bad, dv;
    bit early_ss, ss_bad, stall_bad;
    logic [3:0] ssx;
    logic [31:0] cap, dh, exp;
    dv = sel ? 1 : 4;
    ssx = ~(4'b0001 << ss);
    rx_ready = (hold == 0);
    n = 0;
    while (!go_m && n < 100) begin tick(); n++; end
    chk("go_seen", go_m, 1'b1);
    tick();
    chk("go_pulse", go_m, 1'b0);
    tick();
    DREADY = 1'b1;
    din = {ss, tx};
    n = 0;
    while (!sresp_m && n < 10) begin tick(); n++; end
    chk("sresp_seen", sresp_m, 1'b1);
    srs = 1;
    early_ss = 1'b0;
    for (int i = 0; i < extra; i++) begin
      tick();
      srs += int'(sresp_m);
      if (ss_m !== 4'hF) early_ss = 1'b1;
    end
    DREADY = 1'b0;
    if (drop) begin
      if (sel) start1 = 1'b0;
      else start0 = 1'b0;
    end
    n = 0;
    while (ss_m === 4'hF && n < 10) begin tick(); n++; srs += int'(sresp_m); end
    chk("sresp_once", srs, 1);
    chk("no_early_shift", early_ss, 1'b0);
    chk("ss_n_sel", ss_m, ssx);
    exp_q.push_back(rx);
    miso = rx[bi(0)];
    rises = 0; falls = 0; last_r = -1; first_r = -1; per_bad = 0; ss_bad = 1'b0; cap = '0;
    bad = 1'b0;
    n = 0;
    while (ss_m !== 4'hF && n < 2 * 32 * dv + 4) begin
      if (ss_m !== ssx) ss_bad = 1'b1;
      if (sck_m && !bad) begin
        cap[bi(rises)] = mosi_m;
        if (last_r < 0) first_r = n;
        else if (n - last_r != 2 * dv) per_bad++;
        last_r = n;
        rises++;
        if (abort && rises == 17) break;
      end
      if (!sck_m && bad) begin
        falls++;
        if (falls < 32) miso = rx[bi(falls)];
      end
      bad = sck_m;
      tick();
      n++;
    end
    if (abort) begin
      ARESETN = 1'b0;
      #1;
      chk("abort_ss_n", ss_m, 4'hF);
      chk("abort_sck", sck_m, 1'b0);
      chk("abort_rxv", rxv_m, 1'b0);
      void'(exp_q.pop_back());
      if (sel) start1 = 1'b0;
      else start0 = 1'b0;
      repeat (2) tick();
      ARESETN = 1'b1;
      return;
    end
    chk("shift_len", n, 2 * 32 * dv);
    chk("setup_half", first_r, dv);
    chk("sck_period", per_bad, 0);
    chk("sck_rises", rises, 32);
    chk("ss_one_low", ss_bad, 1'b0);
    chk("mosi_word", cap, tx);
    chk("sck_idle", sck_m, 1'b0);
    n = 0;
    while (!rxv_m && n < dv + 4) begin
      if (ss_m !== 4'hF) ss_bad = 1'b1;
      tick();
      n++;
    end
    chk("desel_len", n, dv);
    chk("desel_ss_n", ss_bad, 1'b0);
    chk("rx_valid", rxv_m, 1'b1);
    if (hold > 0) begin
      dh = rxd_m;
      stall_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!rxv_m || rxd_m !== dh || go_m) stall_bad = 1'b1;
      end
      chk("stall_hold", stall_bad, 1'b0);
      rx_ready = 1'b1;
    end
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
    chk("rx_data", rxd_m, exp);
    tick();
    chk("rx_valid_drop", rxv_m, 1'b0);
    chk("busy_after", busy_m, !drop);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_ctl0", {go0, sresp0, sck0, mosi0, rxv0, busy0}, 6'b0);
    chk("rst_ss_n0", ss0, 4'hF);
    chk("rst_rxd0", rxd0, 32'h0);
    chk("rst_all1", {go1, sresp1, sck1, mosi1, rxv1, busy1, ss1, rxd1}, {6'b0, 4'hF, 32'h0});
    ARESETN = 1'b1;
    start0 = 1'b1;
    frame(2'd2, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
    frame(2'd1, 32'h1234_5678, 32'h0F1E_2D3C, 0, 20, 1'b0, 1'b0);
    frame(2'd3, 32'hCAFE_F00D, 32'h5A5A_A5A5, 3, 0, 1'b0, 1'b0);
    frame(2'd0, 32'h8765_4321, 32'hFFFF_0000, 0, 0, 1'b1, 1'b0);
    bad = 1'b0;
    repeat (10) begin tick(); bad = bad | go0 | busy0; end
    chk("no_go_wo_start", bad, 1'b0);
    start0 = 1'b1;
    frame(2'd1, 32'h0000_0001, 32'h8000_0001, 0, 0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("idle_stays", {busy0, go0}, 2'b00);
    sel = 1'b1;
    start1 = 1'b1;
    frame(2'd0, 32'h1111_2222, 32'h3333_4444, 0, 0, 1'b0, 1'b0);
    frame(2'd1, 32'h5555_6666, 32'h7777_8888, 0, 0, 1'b0, 1'b0);
    frame(2'd3, 32'h9999_AAAA, 32'hBBBB_CCCC, 0, 0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("handshakes0", hs0, 4);
    chk("handshakes1", hs1, 3);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
